// File: rtl/blackjack_game_ctrl.sv
// Single-hand blackjack round controller: bet, deal, player turn, dealer auto-draw, settlement.
// Cards arrive one per req/valid handshake; each card costs at least two cycles (req drops after use).
// Optional soft-ace scoring is enabled by defining SOFT_ACE_EN; the default build counts aces as 1.
module blackjack_game_ctrl #(
    parameter int COIN_W       = 8,
    parameter int INIT_COIN    = 30,
    parameter int DEALER_STAND = 17,
    parameter int BET_W        = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              next_i,
    input  logic              hit_i,
    input  logic              stand_i,
    input  logic              double_i,
    input  logic [BET_W-1:0]  bet_i,
    output logic              card_req_o,
    input  logic              card_valid_i,
    input  logic [3:0]        card_value_i,
    output logic [5:0]        player_score_o,
    output logic [5:0]        dealer_score_o,
    output logic [3:0]        player_new_card_o,
    output logic [COIN_W-1:0] current_coin_o,
    output logic              can_double_o,
    output logic              win_o,
    output logic              lose_o,
    output logic              draw_o,
    output logic              game_over_o,
    output logic [2:0]        state_o
);

`ifdef SOFT_ACE_EN
    localparam bit SoftAce = 1'b1;
`else
    localparam bit SoftAce = 1'b0;
`endif
    localparam int MW = (BET_W > COIN_W) ? BET_W : COIN_W;

    typedef enum logic [2:0] {
        S_BET    = 3'd0,
        S_DEAL   = 3'd1,
        S_PLAYER = 3'd2,
        S_DRAW_P = 3'd3,
        S_DEALER = 3'd4,
        S_RESULT = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [COIN_W-1:0] coin_q, coin_d, bet_q, bet_d;
    logic [5:0]        p_hard_q, p_hard_d, d_hard_q, d_hard_d;
    logic              p_ace_q, p_ace_d, d_ace_q, d_ace_d;
    logic [1:0]        p_cnt_q, p_cnt_d, deal_idx_q, deal_idx_d;
    logic              card_req_q, card_req_d;
    logic [3:0]        new_card_q, new_card_d;
    logic              win_q, win_d, lose_q, lose_d, draw_q, draw_d;
    logic              dbl_q, dbl_d, settled_q, settled_d;

    logic              take, bet_ok, can_dbl, p_ace_nx;
    logic [3:0]        cv;
    logic [5:0]        p_score, d_score, p_hard_nx, p_score_nx, stand_lim;
    logic [1:0]        p_cnt_inc;
    logic [COIN_W+1:0] pay_c, sum_c;

    // Reported score: an ace counts 11 only while that keeps the hand at 21 or below.
    function automatic logic [5:0] score_f(input logic [5:0] hard, input logic ace);
        if (SoftAce && ace && (hard <= 6'd11)) score_f = hard + 6'd10;
        else                                   score_f = hard;
    endfunction

    assign take       = card_req_q & card_valid_i;
    assign cv         = ((card_value_i == 4'd0) || (card_value_i > 4'd10)) ? 4'd10 : card_value_i;
    assign stand_lim  = 6'(DEALER_STAND);
    assign p_score    = score_f(p_hard_q, p_ace_q);
    assign d_score    = score_f(d_hard_q, d_ace_q);
    assign p_hard_nx  = p_hard_q + {2'b00, cv};
    assign p_ace_nx   = p_ace_q | (cv == 4'd1);
    assign p_score_nx = score_f(p_hard_nx, p_ace_nx);
    assign p_cnt_inc  = (p_cnt_q == 2'd3) ? 2'd3 : p_cnt_q + 2'd1;
    assign bet_ok     = (bet_i != '0) && (MW'(bet_i) <= MW'(coin_q));
    assign can_dbl    = (state_q == S_PLAYER) && (p_cnt_q == 2'd2) && (coin_q >= bet_q);

    always_comb begin
        state_d    = state_q;
        coin_d     = coin_q;
        bet_d      = bet_q;
        p_hard_d   = p_hard_q;
        d_hard_d   = d_hard_q;
        p_ace_d    = p_ace_q;
        d_ace_d    = d_ace_q;
        p_cnt_d    = p_cnt_q;
        deal_idx_d = deal_idx_q;
        card_req_d = 1'b0;
        new_card_d = new_card_q;
        win_d      = win_q;
        lose_d     = lose_q;
        draw_d     = draw_q;
        dbl_d      = dbl_q;
        settled_d  = (state_q == S_RESULT);
        pay_c      = '0;
        sum_c      = '0;
        case (state_q)
            S_BET: begin
                if (next_i && bet_ok) begin
                    coin_d     = coin_q - COIN_W'(bet_i);
                    bet_d      = COIN_W'(bet_i);
                    p_hard_d   = '0;
                    d_hard_d   = '0;
                    p_ace_d    = 1'b0;
                    d_ace_d    = 1'b0;
                    p_cnt_d    = '0;
                    deal_idx_d = '0;
                    new_card_d = '0;
                    win_d      = 1'b0;
                    lose_d     = 1'b0;
                    draw_d     = 1'b0;
                    dbl_d      = 1'b0;
                    state_d    = S_DEAL;
                end
            end
            S_DEAL: begin
                card_req_d = ~take;
                if (take) begin
                    deal_idx_d = deal_idx_q + 2'd1;
                    if (!deal_idx_q[0]) begin
                        p_hard_d   = p_hard_nx;
                        p_ace_d    = p_ace_nx;
                        p_cnt_d    = p_cnt_inc;
                        new_card_d = cv;
                    end else begin
                        d_hard_d = d_hard_q + {2'b00, cv};
                        d_ace_d  = d_ace_q | (cv == 4'd1);
                    end
                    if (deal_idx_q == 2'd3)
                        state_d = (p_score == 6'd21) ? S_DEALER : S_PLAYER;
                end
            end
            S_PLAYER: begin
                if (stand_i) begin
                    state_d = S_DEALER;
                end else if (double_i && can_dbl) begin
                    coin_d  = coin_q - bet_q;
                    bet_d   = bet_q << 1;
                    dbl_d   = 1'b1;
                    state_d = S_DRAW_P;
                end else if (hit_i) begin
                    dbl_d   = 1'b0;
                    state_d = S_DRAW_P;
                end
            end
            S_DRAW_P: begin
                card_req_d = ~take;
                if (take) begin
                    p_hard_d   = p_hard_nx;
                    p_ace_d    = p_ace_nx;
                    p_cnt_d    = p_cnt_inc;
                    new_card_d = cv;
                    if (p_score_nx > 6'd21)                     state_d = S_RESULT;
                    else if (dbl_q || (p_score_nx == 6'd21))    state_d = S_DEALER;
                    else                                        state_d = S_PLAYER;
                end
            end
            S_DEALER: begin
                card_req_d = ~take && (d_score < stand_lim);
                if (take) begin
                    d_hard_d = d_hard_q + {2'b00, cv};
                    d_ace_d  = d_ace_q | (cv == 4'd1);
                end else if (!card_req_q && (d_score >= stand_lim)) begin
                    state_d = S_RESULT;
                end
            end
            S_RESULT: begin
                if (!settled_q) begin
                    if (p_score > 6'd21) begin
                        lose_d = 1'b1;
                    end else if ((d_score > 6'd21) || (p_score > d_score)) begin
                        win_d = 1'b1;
                        pay_c = {1'b0, bet_q, 1'b0};
                    end else if (p_score == d_score) begin
                        draw_d = 1'b1;
                        pay_c  = {2'b00, bet_q};
                    end else begin
                        lose_d = 1'b1;
                    end
                    sum_c  = {2'b00, coin_q} + pay_c;
                    coin_d = (sum_c > {2'b00, {COIN_W{1'b1}}}) ? {COIN_W{1'b1}} : sum_c[COIN_W-1:0];
                end else if (next_i) begin
                    win_d   = 1'b0;
                    lose_d  = 1'b0;
                    draw_d  = 1'b0;
                    state_d = S_BET;
                end
            end
            default: state_d = S_BET;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_BET;
            coin_q     <= COIN_W'(INIT_COIN);
            bet_q      <= '0;
            p_hard_q   <= '0;
            d_hard_q   <= '0;
            p_ace_q    <= 1'b0;
            d_ace_q    <= 1'b0;
            p_cnt_q    <= '0;
            deal_idx_q <= '0;
            card_req_q <= 1'b0;
            new_card_q <= '0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
            draw_q     <= 1'b0;
            dbl_q      <= 1'b0;
            settled_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            coin_q     <= coin_d;
            bet_q      <= bet_d;
            p_hard_q   <= p_hard_d;
            d_hard_q   <= d_hard_d;
            p_ace_q    <= p_ace_d;
            d_ace_q    <= d_ace_d;
            p_cnt_q    <= p_cnt_d;
            deal_idx_q <= deal_idx_d;
            card_req_q <= card_req_d;
            new_card_q <= new_card_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
            draw_q     <= draw_d;
            dbl_q      <= dbl_d;
            settled_q  <= settled_d;
        end
    end

    assign card_req_o        = card_req_q;
    assign player_score_o    = p_score;
    assign dealer_score_o    = d_score;
    assign player_new_card_o = new_card_q;
    assign current_coin_o    = coin_q;
    assign can_double_o      = can_dbl;
    assign win_o             = win_q;
    assign lose_o            = lose_q;
    assign draw_o            = draw_q;
    assign game_over_o       = (state_q == S_BET) && (coin_q == '0);
    assign state_o           = state_q;

endmodule

// File: tb/tb_blackjack_game_ctrl.sv
// Directed bench for blackjack_game_ctrl: round outcomes go through a scoreboard queue.
module tb_blackjack_game_ctrl;
    localparam int COIN_W = 8;
    localparam int BET_W  = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              next, hit, stand, dbl;
    logic [BET_W-1:0]  bet;
    logic              card_req, card_valid;
    logic [3:0]        card_value;
    logic [5:0]        player_score, dealer_score;
    logic [3:0]        player_new_card;
    logic [COIN_W-1:0] current_coin;
    logic              can_double, win, lose, draw, game_over;
    logic [2:0]        state;

    blackjack_game_ctrl #(
        .COIN_W(COIN_W), .INIT_COIN(30), .DEALER_STAND(17), .BET_W(BET_W)
    ) dut (
        .clk_i(clk), .reset_ni(reset_n), .next_i(next), .hit_i(hit), .stand_i(stand),
        .double_i(dbl), .bet_i(bet), .card_req_o(card_req), .card_valid_i(card_valid),
        .card_value_i(card_value), .player_score_o(player_score), .dealer_score_o(dealer_score),
        .player_new_card_o(player_new_card), .current_coin_o(current_coin),
        .can_double_o(can_double), .win_o(win), .lose_o(lose), .draw_o(draw),
        .game_over_o(game_over), .state_o(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       w, l, d;
        logic [5:0] ps, ds;
        logic [7:0] coin;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

`ifdef SOFT_ACE_EN
    localparam logic [5:0] ACE_DEAL_SCORE = 6'd17;
`else
    localparam logic [5:0] ACE_DEAL_SCORE = 6'd7;
`endif

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic n, input logic h, input logic s, input logic d);
        next = n; hit = h; stand = s; dbl = d;
        @(negedge clk);
        next = 1'b0; hit = 1'b0; stand = 1'b0; dbl = 1'b0;
    endtask

    task automatic give_card(input logic [3:0] v, input int dly, input string tag);
        int n = 0;
        bit held = 1'b1;
        while (card_req !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req"}, card_req, 1);
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            if (card_req !== 1'b1) held = 1'b0;
        end
        if (dly > 0) chk({tag, "_req_held"}, held, 1);
        card_valid = 1'b1;
        card_value = v;
        @(negedge clk);
        card_valid = 1'b0;
        card_value = 4'd0;
    endtask

    task automatic wait_state(input logic [2:0] s, input string tag);
        int n = 0;
        while (state !== s && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(tag, state, s);
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        wait_state(3'd5, {tag, "_reach_result"});
        @(negedge clk);
        e = sb.pop_front();
        chk({tag, "_win"}, win, e.w);
        chk({tag, "_lose"}, lose, e.l);
        chk({tag, "_draw"}, draw, e.d);
        chk({tag, "_pscore"}, player_score, e.ps);
        chk({tag, "_dscore"}, dealer_score, e.ds);
        chk({tag, "_coin"}, current_coin, e.coin);
    endtask

    task automatic deal4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic [3:0] d, input string tag);
        give_card(a, 0, {tag, "_c0"});
        give_card(b, 0, {tag, "_c1"});
        give_card(c, 0, {tag, "_c2"});
        give_card(d, 0, {tag, "_c3"});
    endtask

    initial begin
        reset_n = 1'b0; next = 1'b0; hit = 1'b0; stand = 1'b0; dbl = 1'b0;
        bet = '0; card_valid = 1'b0; card_value = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_coin", current_coin, 30);
        chk("rst_req", card_req, 0);
        chk("rst_flags", {win, lose, draw, can_double, game_over}, 0);
        chk("rst_scores", {player_score, dealer_score, player_new_card}, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Illegal bets leave the controller parked in BET.
        bet = 5'd0;  pulse(1, 0, 0, 0);
        chk("bet0_state", state, 0);
        chk("bet0_coin", current_coin, 30);
        bet = 5'd31; pulse(1, 0, 0, 0);
        chk("bet31_state", state, 0);
        chk("bet31_coin", current_coin, 30);

        // Round A: stand on 19 against dealer 17, hit+stand coincide.
        sb.push_back('{w: 1'b1, l: 1'b0, d: 1'b0, ps: 6'd19, ds: 6'd17, coin: 8'd35});
        bet = 5'd5; pulse(1, 0, 0, 0);
        chk("A_deal_state", state, 1);
        chk("A_coin_after_bet", current_coin, 25);
        deal4(4'd10, 4'd7, 4'd9, 4'd10, "A");
        chk("A_player_state", state, 2);
        chk("A_can_double", can_double, 1);
        pulse(0, 1, 1, 0);
        chk("A_stand_priority", state, 4);
        check_result("A");
        pulse(1, 0, 0, 0);
        chk("A_back_to_bet", state, 0);
        chk("A_flags_cleared", {win, lose, draw}, 0);

        // Round B: double on 11, dealer draws to 21, push.
        sb.push_back('{w: 1'b0, l: 1'b0, d: 1'b1, ps: 6'd21, ds: 6'd21, coin: 8'd35});
        bet = 5'd4; pulse(1, 0, 0, 0);
        deal4(4'd9, 4'd10, 4'd2, 4'd6, "B");
        chk("B_player_state", state, 2);
        pulse(0, 0, 0, 1);
        chk("B_draw_state", state, 3);
        chk("B_coin_after_double", current_coin, 27);
        give_card(4'd10, 0, "B_dbl");
        chk("B_to_dealer", state, 4);
        give_card(4'd5, 0, "B_dealer");
        check_result("B");
        pulse(1, 0, 0, 0);

        // Round C: hit to bust, dealer never draws.
        sb.push_back('{w: 1'b0, l: 1'b1, d: 1'b0, ps: 6'd24, ds: 6'd14, coin: 8'd30});
        bet = 5'd5; pulse(1, 0, 0, 0);
        deal4(4'd10, 4'd5, 4'd6, 4'd9, "C");
        pulse(0, 1, 0, 0);
        chk("C_hit_state", state, 3);
        give_card(4'd8, 0, "C_hit");
        chk("C_bust_to_result", state, 5);
        chk("C_no_dealer_req", card_req, 0);
        chk("C_new_card", player_new_card, 8);
        check_result("C");
        pulse(1, 0, 0, 0);

        // Round F: all-in loss, then game over and any bet illegal.
        sb.push_back('{w: 1'b0, l: 1'b1, d: 1'b0, ps: 6'd15, ds: 6'd20, coin: 8'd0});
        bet = 5'd30; pulse(1, 0, 0, 0);
        deal4(4'd10, 4'd10, 4'd5, 4'd10, "F");
        chk("F_no_double", can_double, 0);
        pulse(0, 0, 1, 0);
        check_result("F");
        pulse(1, 0, 0, 0);
        chk("F_game_over", game_over, 1);
        bet = 5'd1; pulse(1, 0, 0, 0);
        chk("F_broke_state", state, 0);
        chk("F_broke_coin", current_coin, 0);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("F_reset_coin", current_coin, 30);
        chk("F_reset_game_over", game_over, 0);

        // Round E: ace handling; both builds reach 17 after the hit.
        sb.push_back('{w: 1'b0, l: 1'b0, d: 1'b1, ps: 6'd17, ds: 6'd17, coin: 8'd30});
        bet = 5'd1; pulse(1, 0, 0, 0);
        deal4(4'd1, 4'd5, 4'd6, 4'd5, "E");
        chk("E_ace_score", player_score, ACE_DEAL_SCORE);
        pulse(0, 1, 0, 0);
        give_card(4'd10, 0, "E_hit");
        chk("E_hit_score", player_score, 17);
        chk("E_back_to_player", state, 2);
        pulse(0, 0, 1, 0);
        give_card(4'd7, 0, "E_dealer");
        check_result("E");
        pulse(1, 0, 0, 0);

        // Round D: slow card source, stray valid, then reset mid-DEALER.
        bet = 5'd5; pulse(1, 0, 0, 0);
        give_card(4'd10, 5, "D_slow");
        chk("D_req_dropped", card_req, 0);
        card_valid = 1'b1; card_value = 4'd9;
        @(negedge clk);
        card_valid = 1'b0; card_value = 4'd0;
        chk("D_stray_ignored_p", player_score, 10);
        chk("D_stray_ignored_d", dealer_score, 0);
        give_card(4'd7, 0, "D_c1");
        give_card(4'd2, 0, "D_c2");
        give_card(4'd3, 0, "D_c3");
        pulse(0, 0, 1, 0);
        chk("D_in_dealer", state, 4);
        @(negedge clk);
        chk("D_dealer_req", card_req, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("D_async_state", state, 0);
        chk("D_async_coin", current_coin, 30);
        chk("D_async_req", card_req, 0);
        chk("D_async_flags", {win, lose, draw, can_double}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blackjack_game_ctrl.md
Name: blackjack_game_ctrl

Overview:
Parametrised successor of the single-hand blackjack controller. Runs a full round: bet, deal, player decisions, dealer auto-draw, settlement. Cards arrive from an external card source over a req/valid handshake, so timing no longer depends on free-running card registers. Sits between the debounced/pulsed button front end and the score/coin display logic.

Parameters:
COIN_W, 8, width of coin balance
INIT_COIN, 30, balance loaded at reset
DEALER_STAND, 17, dealer stops drawing at score >= this value
BET_W, 4, width of bet input

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
next  in  1  one-cycle pulse: confirm bet / start next round
hit  in  1  one-cycle pulse
stand  in  1  one-cycle pulse
double  in  1  one-cycle pulse
bet  in  BET_W  requested wager
card_req  out  1  request for one card
card_valid  in  1  card_value valid this cycle
card_value  in  4  card rank 1..10 (1 = ace)
player_score  out  6  player hand total
dealer_score  out  6  dealer hand total
player_new_card  out  4  last card dealt to player
current_coin  out  COIN_W  balance
can_double  out  1  double currently legal
win, lose, draw  out  1 each  round result, held until next round
game_over  out  1  balance zero in BET
state  out  3  FSM state code for debug

Behaviour:
- Reset (asynchronous assert, synchronous release): state=BET, all scores/cards 0, card_req=0, win/lose/draw=0, can_double=0, current_coin=INIT_COIN, internal bet register 0. Reset mid-round abandons the round; the wager is not refunded.
- Handshake: card_req is registered and held high until a cycle with card_req&card_valid; the card is consumed in that cycle and card_req drops the next cycle. card_valid without card_req is ignored. card_value 0 or >10 is counted as 10.
- States/codes: BET=0, DEAL=1, PLAYER=2, DRAW_P=3, DEALER=4, RESULT=5.
- BET: on next with 1 <= bet <= current_coin: latch bet, deduct it from current_coin, clear scores/results, go to DEAL. An illegal bet is ignored (stay in BET). game_over=1 while in BET with current_coin==0.
- DEAL: four cards in order player, dealer, player, dealer. Then go to PLAYER, or to DEALER if player_score==21.
- PLAYER: priority stand > double > hit when pulses coincide.
  - stand: go to DEALER.
  - double: legal only when can_double=1, i.e. exactly two player cards and current_coin >= bet. Deduct bet again, double the bet register, draw one card, then go to DEALER (or RESULT on bust).
  - hit: go to DRAW_P; after the card, return to PLAYER if score <21, go to DEALER if ==21, go to RESULT if >21.
  - Button pulses are ignored in all states other than PLAYER (and next except in BET/RESULT).
- DEALER: request cards while dealer_score < DEALER_STAND, then go to RESULT.
- RESULT (settle one cycle after entry; flags held):
  - player >21: lose.
  - else dealer >21 or player > dealer: win, coin += 2*bet.
  - player == dealer: draw, coin += bet.
  - else: lose.
  - Additions saturate at 2^COIN_W-1.
  - On next, go to BET and clear flags.
- Scores are 6-bit unsigned and cannot overflow (max 30 hard).

Optional Feature:
SOFT_ACE_EN: when defined, each hand tracks a held ace. The reported score is hard+10 if an ace is held and hard+10 <= 21; all comparisons (bust, 21, dealer stand, settlement) use the reported score, and the dealer stands on soft 17. When not defined, ace always counts 1.

Test Plan:
- Reset low mid-DEALER -> state=0, current_coin=30, card_req=0, all flags 0 immediately, without waiting for a clock edge.
- bet=5, next; cards 10,7,9,10; stand -> player 19, dealer 17, win=1, coin 30-5+10=35.
- bet=4, next; cards 9,10,2,6; double; card 10 -> bet 8, player 21; dealer draws 5 -> 21; draw=1, coin 30-8+8=30.
- Hit to bust (cards 10,5,6,9, hit card 8 -> 24) -> RESULT with no dealer draw, lose=1, coin 25.
- bet=0 or bet=31 with coin 30 (BET_W=5 run), next -> stays BET, coin unchanged; hit and stand pulsed in the same cycle -> stand taken.
- card_valid delayed 5 cycles -> card_req held high throughout; extra card_valid after consumption ignored. With SOFT_ACE_EN: player cards 1,6 -> player_score 17; hit 10 -> 17.
